// File: rtl/pc_unit_ras_if.sv
// Fetch-side control/status bundle for the program-counter unit.
// Handshake: no valid/ready pair; every control is a single-cycle qualifier sampled on the rising edge, and freeze is the only backpressure (held controls are dropped, not queued).
interface pc_unit_ras_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 3
);
  logic             freeze;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_addr;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_seq;
  logic [CW-1:0]    ras_count;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output freeze, branch_taken, branch_addr, call, ret,
    input  pc, pc_seq, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  freeze, branch_taken, branch_addr, call, ret,
    output pc, pc_seq, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit_ras.sv
// Program counter with sequential step, branch redirect and a circular return-address stack.
// Priority per edge: reset > freeze > branch (optionally a call) > ret > sequential.
module pc_unit_ras #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic          clk,
  input logic          rst,
  pc_unit_ras_if.slave bus
);
  localparam int unsigned   PW   = $clog2(RAS_DEPTH);
  localparam int unsigned   CW   = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d, pc_seq;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push;

  assign pc_seq = pc_q + WIDTH'(STEP);

  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (!bus.freeze) begin
      if (bus.branch_taken) begin
        pc_d = bus.branch_addr;
        if (bus.call) begin
          // When full, top+1 lands on the oldest entry, so the push overwrites it.
          push  = 1'b1;
          top_d = top_q + PW'(1);
          if (count_q == FULL) ovf_d = 1'b1;
          else                 count_d = count_q + CW'(1);
        end
      end else if (bus.ret) begin
        if (count_q != '0) begin
          pc_d    = ras_mem[top_q];
          top_d   = top_q - PW'(1);
          count_d = count_q - CW'(1);
        end else begin
          pc_d  = pc_seq;
          unf_d = 1'b1;
        end
      end else begin
        pc_d = pc_seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_VECTOR;
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage carries no reset; entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (rst && push) ras_mem[top_d] <= pc_seq;
  end

  assign bus.pc            = pc_q;
  assign bus.pc_seq        = pc_seq;
  assign bus.ras_count     = count_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras: a 32-bit instance for control/stack behaviour and a 16-bit instance for wrap-around.
module tb_pc_unit_ras;
  localparam int EW32 = 32 + 32 + 3 + 2;
  localparam int EW16 = 16 + 16 + 3 + 2;

  logic clk;
  logic rst;
  logic rst16;
  int   n_tests;
  int   n_fail;
  int   step_id;

  logic [EW32-1:0] exp_q[$];
  logic [EW16-1:0] exp16_q[$];

  pc_unit_ras_if #(.WIDTH(32), .CW(3)) b32 ();
  pc_unit_ras_if #(.WIDTH(16), .CW(3)) b16 ();

  pc_unit_ras #(.WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0000_0100), .RAS_DEPTH(4)) dut32 (
    .clk(clk), .rst(rst), .bus(b32.slave)
  );
  pc_unit_ras #(.WIDTH(16), .STEP(4), .RESET_VECTOR(16'hFFFC), .RAS_DEPTH(4)) dut16 (
    .clk(clk), .rst(rst16), .bus(b16.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks: apply one cycle of controls and queue the state expected after that edge
  task automatic step32(input logic r, input logic f, input logic b, input logic [31:0] a,
                        input logic c, input logic rt,
                        input logic [31:0] epc, input logic [2:0] ecnt, input logic eo, input logic eu);
    @(negedge clk);
    rst              = r;
    b32.freeze       = f;
    b32.branch_taken = b;
    b32.branch_addr  = a;
    b32.call         = c;
    b32.ret          = rt;
    exp_q.push_back({epc, epc + 32'd4, ecnt, eo, eu});
  endtask

  task automatic step16(input logic r, input logic rt,
                        input logic [15:0] epc, input logic [15:0] eseq,
                        input logic [2:0] ecnt, input logic eu);
    @(negedge clk);
    rst16            = r;
    b16.freeze       = 1'b0;
    b16.branch_taken = 1'b0;
    b16.branch_addr  = '0;
    b16.call         = 1'b0;
    b16.ret          = rt;
    exp16_q.push_back({epc, eseq, ecnt, 1'b0, eu});
  endtask

  // scoreboard monitor: one expected entry per edge that had stimulus
  always @(posedge clk) begin
    logic [EW32-1:0] e32, a32;
    logic [EW16-1:0] e16, a16;
    #1;
    if (exp_q.size() > 0) begin
      e32 = exp_q.pop_front();
      a32 = {b32.pc, b32.pc_seq, b32.ras_count, b32.ras_overflow, b32.ras_underflow};
      step_id = step_id + 1;
      n_tests = n_tests + 1;
      if (a32 !== e32) begin
        n_fail = n_fail + 1;
        $display("FAIL w32_step%0d got pc=%h seq=%h cnt=%0d ovf=%b unf=%b exp pc=%h seq=%h cnt=%0d ovf=%b unf=%b",
                 step_id, a32[68:37], a32[36:5], a32[4:2], a32[1], a32[0],
                 e32[68:37], e32[36:5], e32[4:2], e32[1], e32[0]);
      end
    end
    if (exp16_q.size() > 0) begin
      e16 = exp16_q.pop_front();
      a16 = {b16.pc, b16.pc_seq, b16.ras_count, b16.ras_overflow, b16.ras_underflow};
      n_tests = n_tests + 1;
      if (a16 !== e16) begin
        n_fail = n_fail + 1;
        $display("FAIL w16_wrap got pc=%h seq=%h cnt=%0d ovf=%b unf=%b exp pc=%h seq=%h cnt=%0d ovf=%b unf=%b",
                 a16[36:21], a16[20:5], a16[4:2], a16[1], a16[0],
                 e16[36:21], e16[20:5], e16[4:2], e16[1], e16[0]);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    step_id = 0;
    rst = 1'b0;
    rst16 = 1'b0;
    b32.freeze = 1'b0; b32.branch_taken = 1'b0; b32.branch_addr = '0; b32.call = 1'b0; b32.ret = 1'b0;
    b16.freeze = 1'b0; b16.branch_taken = 1'b0; b16.branch_addr = '0; b16.call = 1'b0; b16.ret = 1'b0;

    //      rst  frz  br   addr          call ret   pc            cnt   ovf  unf
    // reset and sequential
    step32(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 32'h100, 3'd0, 1'b0, 1'b0);
    step32(1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 32'h100, 3'd0, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 32'h104, 3'd0, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 32'h108, 3'd0, 1'b0, 1'b0);
    // freeze drops a pending branch, then resumes without a skip
    for (int i = 0; i < 3; i++)
      step32(1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 32'h108, 3'd0, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 32'h10C, 3'd0, 1'b0, 1'b0);
    // call / return
    step32(1'b1, 1'b0, 1'b1, 32'h200,   1'b0, 1'b0, 32'h200, 3'd0, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b1, 32'h800,   1'b1, 1'b0, 32'h800, 3'd1, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 32'h804, 3'd1, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 32'h808, 3'd1, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h204, 3'd0, 1'b0, 1'b0);
    // overflow: calls from 0x10..0x50, then four returns in LIFO order
    step32(1'b1, 1'b0, 1'b1, 32'h10,    1'b0, 1'b0, 32'h10,  3'd0, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b1, 32'h20,    1'b1, 1'b0, 32'h20,  3'd1, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b1, 32'h30,    1'b1, 1'b0, 32'h30,  3'd2, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b1, 32'h40,    1'b1, 1'b0, 32'h40,  3'd3, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b1, 32'h50,    1'b1, 1'b0, 32'h50,  3'd4, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b1, 32'h60,    1'b1, 1'b0, 32'h60,  3'd4, 1'b1, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h54,  3'd3, 1'b1, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h44,  3'd2, 1'b1, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h34,  3'd1, 1'b1, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h24,  3'd0, 1'b1, 1'b0);
    // underflow
    step32(1'b1, 1'b0, 1'b1, 32'h300,   1'b0, 1'b0, 32'h300, 3'd0, 1'b1, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h304, 3'd0, 1'b1, 1'b1);
    // branch wins over ret; the stacked entry survives
    step32(1'b1, 1'b0, 1'b1, 32'h500,   1'b1, 1'b0, 32'h500, 3'd1, 1'b1, 1'b1);
    step32(1'b1, 1'b0, 1'b1, 32'h900,   1'b0, 1'b1, 32'h900, 3'd1, 1'b1, 1'b1);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h308, 3'd0, 1'b1, 1'b1);
    // call without branch is a plain step; frozen ret/call are dropped
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 32'h30C, 3'd0, 1'b1, 1'b1);
    step32(1'b1, 1'b1, 1'b1, 32'hA00,   1'b1, 1'b0, 32'h30C, 3'd0, 1'b1, 1'b1);
    step32(1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h30C, 3'd0, 1'b1, 1'b1);
    // push one entry, then reset with a coincident call: everything clears
    step32(1'b1, 1'b0, 1'b1, 32'h700,   1'b1, 1'b0, 32'h700, 3'd1, 1'b1, 1'b1);
    step32(1'b0, 1'b1, 1'b1, 32'hB00,   1'b1, 1'b0, 32'h100, 3'd0, 1'b0, 1'b0);
    step32(1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h104, 3'd0, 1'b0, 1'b1);

    // 16-bit wrap: reset vector 0xFFFC steps to 0x0000
    step16(1'b0, 1'b0, 16'hFFFC, 16'h0000, 3'd0, 1'b0);
    step16(1'b1, 1'b0, 16'h0000, 16'h0004, 3'd0, 1'b0);
    step16(1'b1, 1'b1, 16'h0004, 16'h0008, 3'd0, 1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
